// File: rtl/multicycle_control.sv
// Multicycle RISC-V controller: sequences FETCH/DECODE/EXECUTE/WRITEBACK and
// drives the ALU code, datapath mux selects and write enables.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal decode enters a sticky TRAP state).
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       RegWrite,
  output logic       illegal
);

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;

  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluXor = 4'b0100;
  localparam logic [3:0] AluSrl = 4'b0101;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
`ifdef ILLEGAL_TRAP_EN
    StBeq,
    StTrap
`else
    StBeq
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] funct_alu;
  logic       funct_ok;
  logic       legal;

  // State register; the only sequential element.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // Funct decode for R/I arithmetic; funct7b5 is an immediate bit for addi/xori.
  always_comb begin
    funct_alu = AluAdd;
    funct_ok  = 1'b0;
    if (opcode == OpR) begin
      unique case ({funct7b5, funct3})
        4'b0000: begin funct_alu = AluAdd; funct_ok = 1'b1; end
        4'b1000: begin funct_alu = AluSub; funct_ok = 1'b1; end
        4'b0100: begin funct_alu = AluXor; funct_ok = 1'b1; end
        4'b0101: begin funct_alu = AluSrl; funct_ok = 1'b1; end
        default: ;
      endcase
    end else begin
      unique case (funct3)
        3'b000:  begin funct_alu = AluAdd; funct_ok = 1'b1; end
        3'b100:  begin funct_alu = AluXor; funct_ok = 1'b1; end
        3'b101:  begin funct_alu = AluSrl; funct_ok = !funct7b5; end
        default: ;
      endcase
    end
  end

  // Instruction legality, consulted only in DECODE.
  always_comb begin
    unique case (opcode)
      OpLw, OpSw: legal = 1'b1;
      OpR, OpI:   legal = funct_ok;
      OpBeq:      legal = (funct3 == 3'b000);
      default:    legal = 1'b0;
    endcase
  end

  // Next-state and Moore outputs; only PCWrite/IRWrite see mem_ready/zero directly.
  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = AluAdd;
    RegWrite   = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      StFetch: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = StTrap;
`else
          state_d = StFetch;
`endif
        end else begin
          unique case (opcode)
            OpLw, OpSw: state_d = StMemAdr;
            OpR:        state_d = StExecR;
            OpI:        state_d = StExecI;
            default:    state_d = StBeq;
          endcase
        end
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExecR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = funct_alu;
        state_d    = StAluWb;
      end
      StExecI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = funct_alu;
        state_d    = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StBeq: begin
        ALUSrcA    = 2'b10;
        ALUControl = AluSub;
        PCWrite    = zero;
        state_d    = StFetch;
      end
`ifdef ILLEGAL_TRAP_EN
      StTrap: begin
        illegal = 1'b1;
        state_d = StTrap;
      end
`endif
      default: state_d = StFetch;
    endcase

    // Reset overrides everything so an abandoned instruction writes nothing.
    if (reset) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = AluAdd;
      RegWrite   = 1'b0;
      illegal    = 1'b0;
    end
  end

  // Immediate format follows the opcode directly.
  always_comb begin
    ImmSrc = 2'b00;
    if (!reset) begin
      if (opcode == OpSw)       ImmSrc = 2'b01;
      else if (opcode == OpBeq) ImmSrc = 2'b10;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle and compares the full output vector against hand-written expectations.
module tb_multicycle_control;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] XOR = 4'b0100;
  localparam logic [3:0] SRL = 4'b0101;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl;
  logic [17:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite),
    .illegal    (illegal)
  );

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
                ALUControl, RegWrite, illegal};

  // Output vector: pcw adr mw irw | rsrc srca srcb imm | alu | rw ill
  function automatic logic [17:0] sg(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] im, input logic [3:0] alu,
                                     input logic rw, input logic il);
    return {pcw, adr, mw, irw, rs, sa, sb, im, alu, rw, il};
  endfunction

  function automatic logic [17:0] e_fetch(input logic mr, input logic [1:0] im);
    return sg(mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, im, ADD, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] e_decode(input logic [1:0] im);
    return sg(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, im, ADD, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] e_memadr(input logic [1:0] im);
    return sg(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, im, ADD, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] e_execr(input logic [3:0] alu);
    return sg(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] e_execi(input logic [3:0] alu);
    return sg(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 1'b0, 1'b0);
  endfunction
  function automatic logic [17:0] e_beq(input logic z);
    return sg(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, SUB, 1'b0, 1'b0);
  endfunction

  localparam logic [17:0] E_RST     = {4'b0000, 8'h00, ADD, 2'b00};
  localparam logic [17:0] E_MEMREAD = {4'b0100, 8'h00, ADD, 2'b00};
  localparam logic [17:0] E_MEMWB   = {4'b0000, 8'b01_00_00_00, ADD, 2'b10};
  localparam logic [17:0] E_MEMWR   = {4'b0110, 8'b00_00_00_01, ADD, 2'b00};
  localparam logic [17:0] E_ALUWB   = {4'b0000, 8'h00, ADD, 2'b10};
  localparam logic [17:0] E_TRAP    = {4'b0000, 8'h00, ADD, 2'b01};

  // Inputs are applied at a falling edge; outputs are checked 1 time unit later,
  // then the next rising edge consumes those inputs.
  task automatic step(input string tag, input logic [17:0] exp);
    #1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
    @(negedge clk);
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode   = op;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    instr(OP_R, 3'b000, 1'b0);
    @(negedge clk);
    step("reset_outputs", E_RST);
    reset = 1'b0;

    // add
    step("add_fetch", e_fetch(1'b1, 2'b00));
    step("add_decode", e_decode(2'b00));
    step("add_execr", e_execr(ADD));
    step("add_aluwb", E_ALUWB);
    // sub
    instr(OP_R, 3'b000, 1'b1);
    step("sub_fetch", e_fetch(1'b1, 2'b00));
    step("sub_decode", e_decode(2'b00));
    step("sub_execr", e_execr(SUB));
    step("sub_aluwb", E_ALUWB);
    // srl
    instr(OP_R, 3'b101, 1'b0);
    step("srl_fetch", e_fetch(1'b1, 2'b00));
    step("srl_decode", e_decode(2'b00));
    step("srl_execr", e_execr(SRL));
    step("srl_aluwb", E_ALUWB);
    // xori
    instr(OP_I, 3'b100, 1'b1);
    step("xori_fetch", e_fetch(1'b1, 2'b00));
    step("xori_decode", e_decode(2'b00));
    step("xori_execi", e_execi(XOR));
    step("xori_aluwb", E_ALUWB);

    // lw with two wait cycles in MEMREAD
    instr(OP_LW, 3'b010, 1'b0);
    step("lw_fetch", e_fetch(1'b1, 2'b00));
    step("lw_decode", e_decode(2'b00));
    step("lw_memadr", e_memadr(2'b00));
    mem_ready = 1'b0;
    step("lw_memread0", E_MEMREAD);
    step("lw_memread1", E_MEMREAD);
    mem_ready = 1'b1;
    step("lw_memread2", E_MEMREAD);
    step("lw_memwb", E_MEMWB);

    // sw with a FETCH stall and a MEMWRITE stall
    instr(OP_SW, 3'b010, 1'b0);
    mem_ready = 1'b0;
    step("sw_fetch_stall", e_fetch(1'b0, 2'b01));
    mem_ready = 1'b1;
    step("sw_fetch", e_fetch(1'b1, 2'b01));
    step("sw_decode", e_decode(2'b01));
    step("sw_memadr", e_memadr(2'b01));
    mem_ready = 1'b0;
    step("sw_memwrite_wait", E_MEMWR);
    mem_ready = 1'b1;
    step("sw_memwrite_done", E_MEMWR);

    // beq taken / not taken
    instr(OP_BEQ, 3'b000, 1'b0);
    zero = 1'b1;
    step("beq_t_fetch", e_fetch(1'b1, 2'b10));
    step("beq_t_decode", e_decode(2'b10));
    step("beq_taken", e_beq(1'b1));
    zero = 1'b0;
    step("beq_n_fetch", e_fetch(1'b1, 2'b10));
    step("beq_n_decode", e_decode(2'b10));
    step("beq_not_taken", e_beq(1'b0));

    // reset asserted mid-MEMWRITE
    instr(OP_SW, 3'b010, 1'b0);
    step("swr_fetch", e_fetch(1'b1, 2'b01));
    step("swr_decode", e_decode(2'b01));
    step("swr_memadr", e_memadr(2'b01));
    mem_ready = 1'b0;
    step("swr_memwrite", E_MEMWR);
    reset = 1'b1;
    step("swr_reset_same_cycle", E_RST);
    reset = 1'b0;
    mem_ready = 1'b1;
    step("swr_after_reset_fetch", e_fetch(1'b1, 2'b01));

    // illegal: srli with funct7b5=1, then opcode 1111111
    instr(OP_I, 3'b101, 1'b1);
    step("srli_bad_decode", e_decode(2'b00));
`ifdef ILLEGAL_TRAP_EN
    step("srli_bad_trap", E_TRAP);
    reset = 1'b1;
    step("srli_bad_reset", E_RST);
    reset = 1'b0;
`endif
    instr(OP_BAD, 3'b000, 1'b0);
    step("bad_fetch", e_fetch(1'b1, 2'b00));
    step("bad_decode", e_decode(2'b00));
`ifdef ILLEGAL_TRAP_EN
    step("bad_trap0", E_TRAP);
    step("bad_trap1", E_TRAP);
    reset = 1'b1;
    step("bad_reset", E_RST);
    reset = 1'b0;
`endif
    instr(OP_R, 3'b000, 1'b0);
    step("post_illegal_fetch", e_fetch(1'b1, 2'b00));
    step("post_illegal_decode", e_decode(2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
